hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline control unit for the five-stage CPU. It drives the hold, stall, flush and bubble controls consumed by the PC, the IF/ID register and the ID/EX register. It arbitrates three hazard sources: data-cache miss stalls, load-use hazards, and taken branches/jumps resolved in ID. It also defers any flush requested during a memory stall, because IF/ID gives flush priority over stall and would otherwise corrupt a held instruction.

## Interface
Parameters:
- CNT_W, 16, width of the saturating performance counters

Ports:
- clk_i  in  1  clock; state updates on posedge, pipeline registers sample outputs on negedge
- rst_i  in  1  synchronous, active-low reset
- dcache_stall_i  in  1  data cache busy (miss in progress)
- IDEX_MemRead_i  in  1  instruction in EX is a load
- IDEX_Rt_i  in  5  load destination register
- IFID_Rs_i  in  5  ID source register rs
- IFID_Rt_i  in  5  ID source register rt
- branch_taken_i  in  1  ID resolved a taken branch or jump
- PCWrite_o  out  1  1 = PC may update
- IFIDWrite_o  out  1  1 = IF/ID holds its contents; 0 = IF/ID loads
- stall_o  out  1  global memory stall to all pipeline registers
- flush_o  out  1  IF/ID instruction replaced by NOP
- bubble_o  out  1  ID/EX control fields zeroed
- stall_cnt_o  out  CNT_W  cycles spent stalled (memory or load-use)
- flush_cnt_o  out  CNT_W  flushes issued

## Operation
- Load-use condition `lu` = IDEX_MemRead_i && IDEX_Rt_i != 0 && (IDEX_Rt_i == IFID_Rs_i || IDEX_Rt_i == IFID_Rt_i).
- FSM states:
  - RUN: no pending work.
  - MWAIT: memory stall, no flush pending.
  - MWAIT_FL: memory stall with a flush pending.
- Output priority, evaluated combinationally each cycle:
  1. **Reset** (rst_i = 0): PCWrite_o = 0, IFIDWrite_o = 0, stall_o = 0, bubble_o = 0, flush_o = 1.
  2. **Memory stall** (dcache_stall_i = 1): stall_o = 1, PCWrite_o = 0, IFIDWrite_o = 1, flush_o = 0, bubble_o = 0.
  3. **Pending flush** (state MWAIT_FL, stall low): flush_o = 1, PCWrite_o = 1, IFIDWrite_o = 0. The deferred branch target is already in the PC.
  4. **Load-use** (`lu` = 1): PCWrite_o = 0, IFIDWrite_o = 1, bubble_o = 1, flush_o = 0. A branch_taken_i arriving in the same cycle is ignored, because its operands are not yet valid.
  5. **Branch** (branch_taken_i = 1): flush_o = 1, PCWrite_o = 1, IFIDWrite_o = 0.
  6. **Otherwise**: PCWrite_o = 1, all other controls 0.
- Transitions (posedge):
  - RUN to MWAIT: dcache_stall_i && !branch_taken_i.
  - RUN to MWAIT_FL: dcache_stall_i && branch_taken_i.
  - MWAIT to MWAIT_FL: dcache_stall_i && branch_taken_i.
  - MWAIT to RUN: !dcache_stall_i.
  - MWAIT_FL stays put while dcache_stall_i; returns to RUN on !dcache_stall_i, i.e. in the same cycle the deferred flush is output.
  - A repeated branch_taken_i during MWAIT_FL is absorbed; exactly one flush is issued.
- Counters:
  - stall_cnt_o increments on each cycle with stall_o || bubble_o.
  - flush_cnt_o increments on each cycle with flush_o while rst_i = 1.
  - Both saturate at 2^CNT_W − 1 and never wrap.

## Timing
- Reset values: state RUN, stall_cnt_o = 0, flush_cnt_o = 0. Reset output levels are given in Operation item 1.
- Reset asserted mid-stall returns the FSM to RUN on the next posedge, and any pending flush is dropped.
- Outputs are combinational from the current state and inputs, with zero latency. They must settle within the high phase so the negedge-clocked pipeline registers capture them.
- flush_o and stall_o are never both 1.
- A load-use stall lasts exactly one cycle. The next cycle sees the load in MEM, so `lu` clears naturally.
- A deferred flush appears on the first cycle with dcache_stall_i low and lasts exactly one cycle.

## Structure
- Shared header pipe_defs.vh holds the state encodings (RUN = 2'd0, MWAIT = 2'd1, MWAIT_FL = 2'd2) and the register-zero constant.
- Sub-module sat_cnt(W) provides a saturating incrementer with inc and synchronous active-low reset; it is instantiated twice.
- State 2'd3 is illegal and recovers to RUN.

## Test plan
- **Reset and idle:** rst_i = 0 for 2 cycles, then 1 with no hazards. Expect flush_o = 1 during reset, then PCWrite_o = 1 and all other controls 0, counters 0.
- **Load-use:** IDEX_MemRead_i = 1, IDEX_Rt_i = 8, IFID_Rs_i = 8. Expect one cycle of PCWrite_o = 0, IFIDWrite_o = 1, bubble_o = 1, and stall_cnt_o = 1. Repeat with IDEX_Rt_i = 0: expect no stall.
- **Branch:** branch_taken_i = 1 for one cycle. Expect a single-cycle flush_o = 1 and flush_cnt_o = 1.
- **Branch during miss:** dcache_stall_i high for 5 cycles, branch_taken_i pulsed in cycles 2 and 4. Expect flush_o = 0 throughout the stall, exactly one flush_o on the first cycle after the stall, flush_cnt_o = 1, and stall_cnt_o = 5.
- **Load-use plus branch:** `lu` and branch_taken_i together. Expect bubble_o = 1 and flush_o = 0.
- **Saturation:** with CNT_W = 4, run 20 stall cycles. Expect stall_cnt_o to hold at 15.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_pkg
//  Description : Shared types, constants and helpers for the pipeline hazard
//                control unit (FSM state encoding, register-zero constant,
//                load-use detection).
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

    // Controller states. Encoding 2'd3 is unused and recovers to RUN.
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,  // no pending work
        ST_MWAIT    = 2'd1,  // memory stall, no flush pending
        ST_MWAIT_FL = 2'd2   // memory stall with a deferred flush
    } hz_state_e;

    // Architectural register zero: never a real dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Load-use hazard: the load in EX writes a register the ID instruction
    // reads. Register zero is hard-wired, so it never creates a hazard.
    function automatic logic load_use(
        input logic       idex_memread,
        input logic [4:0] idex_rt,
        input logic [4:0] ifid_rs,
        input logic [4:0] ifid_rt
    );
        return idex_memread && (idex_rt != REG_ZERO) &&
               ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
    endfunction

endpackage : hazard_ctrl_pkg
`default_nettype wire

// File: rtl/hazard_ctrl_sat_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_sat_cnt
//  Description : Saturating up-counter with increment enable and synchronous
//                active-low reset. Holds at all-ones instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: step by one unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register with synchronous active-low clear.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : hazard_ctrl_sat_cnt
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Five-stage pipeline control unit. Arbitrates data-cache
//                stalls, load-use hazards and ID-resolved taken branches into
//                PC / IF-ID / ID-EX controls. Flushes requested while memory
//                is stalled are deferred until the stall releases, because
//                IF/ID lets flush override stall and would destroy the held
//                instruction. Also keeps saturating stall/flush counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             dcache_stall_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_Rt_i,
    input  logic [4:0]       IFID_Rs_i,
    input  logic [4:0]       IFID_Rt_i,
    input  logic             branch_taken_i,
    output logic             PCWrite_o,
    output logic             IFIDWrite_o,
    output logic             stall_o,
    output logic             flush_o,
    output logic             bubble_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    hz_state_e state_q;
    hz_state_e state_d;
    logic      lu;
    logic      flush_pending;

    assign lu = load_use(IDEX_MemRead_i, IDEX_Rt_i, IFID_Rs_i, IFID_Rt_i);

    // Only MWAIT_FL carries a deferred flush; anything else (including the
    // unused encoding) behaves as if nothing is pending.
    assign flush_pending = (state_q == ST_MWAIT_FL);

    // State register; reset drops any pending flush.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: remember a taken branch seen while memory is stalled.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (dcache_stall_i) begin
                    state_d = branch_taken_i ? ST_MWAIT_FL : ST_MWAIT;
                end
            end
            ST_MWAIT: begin
                if (!dcache_stall_i) begin
                    state_d = ST_RUN;
                end else if (branch_taken_i) begin
                    state_d = ST_MWAIT_FL;
                end
            end
            ST_MWAIT_FL: begin
                // Further branches are absorbed: one flush only.
                if (!dcache_stall_i) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Output arbitration, highest priority first:
    // reset, memory stall, deferred flush, load-use, branch, normal flow.
    always_comb begin
        PCWrite_o   = 1'b1;
        IFIDWrite_o = 1'b0;
        stall_o     = 1'b0;
        flush_o     = 1'b0;
        bubble_o    = 1'b0;
        if (!rst_i) begin
            PCWrite_o = 1'b0;
            flush_o   = 1'b1;
        end else if (dcache_stall_i) begin
            stall_o     = 1'b1;
            PCWrite_o   = 1'b0;
            IFIDWrite_o = 1'b1;
        end else if (flush_pending) begin
            // Branch target already sits in the PC; just kill IF/ID once.
            flush_o = 1'b1;
        end else if (lu) begin
            // Branch operands are not valid yet, so any branch is ignored.
            PCWrite_o   = 1'b0;
            IFIDWrite_o = 1'b1;
            bubble_o    = 1'b1;
        end else if (branch_taken_i) begin
            flush_o = 1'b1;
        end
    end

    hazard_ctrl_sat_cnt #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (stall_o | bubble_o),
        .cnt_o (stall_cnt_o)
    );

    hazard_ctrl_sat_cnt #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (flush_o & rst_i),
        .cnt_o (flush_cnt_o)
    );

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl with a behavioural
//                reference model, directed scenarios and random stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             dstall;
    logic             memrd;
    logic [4:0]       ex_rt;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             br;
    logic             pcw, ifidw, stl, fl, bub;
    logic [CNT_W-1:0] scnt, fcnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Model state: a flush is owed; expected counter values.
    logic m_pend = 1'b0;
    int   m_scnt = 0;
    int   m_fcnt = 0;
    logic chk_en = 1'b0;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .dcache_stall_i (dstall),
        .IDEX_MemRead_i (memrd),
        .IDEX_Rt_i      (ex_rt),
        .IFID_Rs_i      (id_rs),
        .IFID_Rt_i      (id_rt),
        .branch_taken_i (br),
        .PCWrite_o      (pcw),
        .IFIDWrite_o    (ifidw),
        .stall_o        (stl),
        .flush_o        (fl),
        .bubble_o       (bub),
        .stall_cnt_o    (scnt),
        .flush_cnt_o    (fcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected controls packed as {PCWrite, IFIDWrite, stall, flush, bubble}.
    function automatic logic [4:0] model_out(
        input logic r, input logic s, input logic pend, input logic mr,
        input logic [4:0] xrt, input logic [4:0] rs, input logic [4:0] rt,
        input logic b
    );
        logic hz;
        hz = mr && (xrt != 5'd0) && (xrt == rs || xrt == rt);
        if (!r)   return 5'b00010;
        if (s)    return 5'b01100;
        if (pend) return 5'b10010;
        if (hz)   return 5'b01001;
        if (b)    return 5'b10010;
        return 5'b10000;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic apply(input logic r, input logic s, input logic mr,
                         input logic [4:0] xrt, input logic [4:0] rs,
                         input logic [4:0] rt, input logic b);
        rst_n = r; dstall = s; memrd = mr;
        ex_rt = xrt; id_rs = rs; id_rt = rt; br = b;
    endtask

    // Advance one clock; update the model from the inputs seen at the edge.
    task automatic tick();
        logic [4:0] o;
        @(posedge clk);
        o = model_out(rst_n, dstall, m_pend, memrd, ex_rt, id_rs, id_rt, br);
        if (!rst_n) begin
            m_pend = 1'b0; m_scnt = 0; m_fcnt = 0;
        end else begin
            if (o[2] || o[0]) m_scnt = (m_scnt < CNT_MAX) ? m_scnt + 1 : CNT_MAX;
            if (o[1])         m_fcnt = (m_fcnt < CNT_MAX) ? m_fcnt + 1 : CNT_MAX;
            m_pend = dstall ? (m_pend | br) : 1'b0;
        end
        #1;
    endtask

    // Per-cycle comparison against the model, on the capture edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("controls", int'({pcw, ifidw, stl, fl, bub}),
                  int'(model_out(rst_n, dstall, m_pend, memrd, ex_rt, id_rs, id_rt, br)));
            check("stall_cnt", int'(scnt), m_scnt);
            check("flush_cnt", int'(fcnt), m_fcnt);
            if (stl && fl) check("flush_and_stall", 1, 0);
        end
    end

    initial begin
        logic s_burst;
        apply(0, 0, 0, 0, 0, 0, 0);
        chk_en = 1'b1;

        // Reset and idle
        @(negedge clk);
        check("reset_flush", int'(fl), 1);
        check("reset_pcw", int'(pcw), 0);
        tick(); tick();
        apply(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("idle_ctrl", int'({pcw, ifidw, stl, fl, bub}), 5'b10000);
        check("idle_cnt", int'(scnt) + int'(fcnt), 0);
        tick();

        // Load-use on rs
        apply(1, 0, 1, 5'd8, 5'd8, 5'd3, 0);
        @(negedge clk);
        check("lu_ctrl", int'({pcw, ifidw, bub}), 3'b011);
        tick();
        apply(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("lu_stall_cnt", int'(scnt), 1);
        tick();

        // Load into r0 is never a hazard
        apply(1, 0, 1, 5'd0, 5'd0, 5'd0, 0);
        @(negedge clk);
        check("lu_r0_bubble", int'(bub), 0);
        check("lu_r0_pcw", int'(pcw), 1);
        tick();

        // Single branch
        apply(1, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        check("br_flush", int'(fl), 1);
        tick();
        apply(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("br_flush_cnt", int'(fcnt), 1);
        check("br_flush_gone", int'(fl), 0);
        tick();

        // Branch during a 5-cycle miss, pulsed in cycles 2 and 4
        for (int c = 1; c <= 5; c++) begin
            apply(1, 1, 0, 0, 0, 0, (c == 2 || c == 4));
            @(negedge clk);
            check("miss_no_flush", int'(fl), 0);
            tick();
        end
        apply(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("deferred_flush", int'(fl), 1);
        check("miss_stall_cnt", int'(scnt), 6);
        tick();
        @(negedge clk);
        check("deferred_once", int'(fl), 0);
        check("miss_flush_cnt", int'(fcnt), 2);
        tick();

        // Load-use and branch together: branch ignored
        apply(1, 0, 1, 5'd5, 5'd1, 5'd5, 1);
        @(negedge clk);
        check("lubr_bubble", int'(bub), 1);
        check("lubr_flush", int'(fl), 0);
        tick();

        // Randomized traffic with stall bursts and rare resets
        s_burst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 4) == 0) s_burst = ~s_burst;
            apply(($urandom_range(0, 79) != 0), s_burst,
                  ($urandom_range(0, 2) == 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
            tick();
        end

        // Saturation: reset, then 20 stall cycles
        apply(0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int c = 0; c < 20; c++) begin
            apply(1, 1, 0, 0, 0, 0, 0);
            tick();
        end
        apply(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("sat_stall_cnt", int'(scnt), 15);
        tick();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_hazard_ctrl
`default_nettype wire
